// File: rtl/dff_4_sync_clear_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_4_sync_clear_pkg
// Description : Shared constants for the sync-clear D flip-flop family.
// Revision    : 1.0 - initial release
// ============================================================================
package dff_4_sync_clear_pkg;

   // Default register width: a single storage bit.
   localparam int DFF_WIDTH = 1;

   // Level of the clear input that forces the register to its clear value.
   localparam logic CLEAR_ACTIVE = 1'b0;

endpackage : dff_4_sync_clear_pkg
`default_nettype wire

// File: rtl/dff_4_sync_clear_bit_cell.sv
`default_nettype none
// ============================================================================
// Module      : dff_bit_cell
// Description : One storage bit, rising-edge clocked, synchronous
//               active-low clear with a per-bit clear value.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_bit_cell #(
   parameter logic CLEAR_BIT = 1'b0
) (
   input  logic clk,
   input  logic clear,
   input  logic d,
   output logic q
);

   // Capture d on each rising edge, or load CLEAR_BIT when clear is low.
   // The conditional operator (rather than an if) lets an unknown clear
   // merge d and CLEAR_BIT, so X is reported instead of silently masked.
   always_ff @(posedge clk) begin
      q <= clear ? d : CLEAR_BIT;
   end

endmodule : dff_bit_cell
`default_nettype wire

// File: rtl/dff_4_sync_clear.sv
`default_nettype none
// ============================================================================
// Module      : dff_4_sync_clear
// Description : WIDTH-bit D register with synchronous active-low clear and
//               complementary outputs. qb is derived from q, never stored.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_4_sync_clear
   import dff_4_sync_clear_pkg::*;
#(
   parameter int               WIDTH       = DFF_WIDTH,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb
);

   // One independent storage cell per bit, each with its own clear value.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         dff_bit_cell #(
            .CLEAR_BIT (CLEAR_VALUE[i])
         ) u_cell (
            .clk   (clk),
            .clear (clear),
            .d     (d[i]),
            .q     (q[i])
         );
      end
   endgenerate

   // Complement comes straight from the stored bits so q and qb always agree.
   assign qb = ~q;

endmodule : dff_4_sync_clear
`default_nettype wire

// File: tb/tb_dff_4_sync_clear.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_4_sync_clear
// Description : Self-checking bench for dff_4_sync_clear (1-bit and 4-bit
//               instances) against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_4_sync_clear;

   logic       clk = 1'b0;
   logic       clear;
   logic       d1;
   logic [3:0] d4;
   logic [3:0] d4b;
   logic       q1, qb1;
   logic [3:0] q4, qb4;
   logic [3:0] q4b, qb4b;

   int checks = 0;
   int fails  = 0;

   // Reference model state: what each register must hold after the last edge.
   logic       m1;
   logic [3:0] m4;
   logic [3:0] m4b;
   bit         model_valid = 1'b0;

   localparam logic [3:0] CV_B = 4'b1001;

   dff_4_sync_clear u_dut1 (
      .clk   (clk),
      .clear (clear),
      .d     (d1),
      .q     (q1),
      .qb    (qb1)
   );

   dff_4_sync_clear #(.WIDTH(4), .CLEAR_VALUE(4'b0000)) u_dut4 (
      .clk   (clk),
      .clear (clear),
      .d     (d4),
      .q     (q4),
      .qb    (qb4)
   );

   dff_4_sync_clear #(.WIDTH(4), .CLEAR_VALUE(CV_B)) u_dut4b (
      .clk   (clk),
      .clear (clear),
      .d     (d4b),
      .q     (q4b),
      .qb    (qb4b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: at each rising edge the register takes d, or the clear value when clear is low.
   always @(posedge clk) begin
      m1  = (clear == 1'b1) ? d1  : 1'b0;
      m4  = (clear == 1'b1) ? d4  : 4'b0000;
      m4b = (clear == 1'b1) ? d4b : CV_B;
      model_valid = 1'b1;
   end

   // Compare every cycle, mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (model_valid) begin
         chk("q1",   {3'b000, q1},  {3'b000, m1});
         chk("qb1",  {3'b000, qb1}, {3'b000, ~m1});
         chk("q4",   q4,   m4);
         chk("qb4",  qb4,  ~m4);
         chk("q4b",  q4b,  m4b);
         chk("qb4b", qb4b, ~m4b);
      end
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      logic [4:0] pattern;
      logic       saved1;
      logic [3:0] saved4;
      logic       final_d1;

      clear = 1'b1;
      d1    = 1'b0;
      d4    = 4'b0000;
      d4b   = 4'b0000;

      // Capture 0 at the first edge (t=5).
      @(negedge clk);
      chk("cap0_q",  {3'b000, q1},  4'b0000);
      chk("cap0_qb", {3'b000, qb1}, 4'b0001);

      // Toggle tracking: 1,0,1,0,1 applied on falling edges.
      pattern = 5'b10101;
      for (int i = 4; i >= 0; i--) begin
         d1 = pattern[i];
         @(negedge clk);
         chk("toggle_q",  {3'b000, q1},  {3'b000, pattern[i]});
         chk("toggle_qb", {3'b000, qb1}, {3'b000, ~pattern[i]});
      end

      // Synchronous clear asserted mid-cycle (t=60): no effect before t=65.
      d1    = 1'b1;
      clear = 1'b0;
      #4;
      chk("clr_hold_q", {3'b000, q1}, 4'b0001);
      @(posedge clk); #1;
      chk("clr_q",  {3'b000, q1},  4'b0000);
      chk("clr_qb", {3'b000, qb1}, 4'b0001);
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      chk("rel_q",  {3'b000, q1},  4'b0001);
      chk("rel_qb", {3'b000, qb1}, 4'b0000);

      // Clear priority over d for three edges.
      @(negedge clk);
      clear = 1'b0;
      d1    = 1'b1;
      d4    = 4'b1111;
      d4b   = 4'b0110;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("prio_q1",  {3'b000, q1}, 4'b0000);
         chk("prio_q4",  q4,  4'b0000);
         chk("prio_q4b", q4b, 4'b1001);
      end

      // WIDTH=4 load then clear.
      @(negedge clk);
      clear = 1'b1;
      d4    = 4'b1010;
      d4b   = 4'b1010;
      @(posedge clk); #1;
      chk("w4_q",  q4,  4'b1010);
      chk("w4_qb", qb4, 4'b0101);
      @(negedge clk);
      clear = 1'b0;
      @(posedge clk); #1;
      chk("w4clr_q",   q4,   4'b0000);
      chk("w4clr_qb",  qb4,  4'b1111);
      chk("w4bclr_q",  q4b,  4'b1001);
      chk("w4bclr_qb", qb4b, 4'b0110);

      // Glitch immunity: clear pulse and d toggles entirely between edges.
      @(negedge clk);
      clear = 1'b1;
      d1    = 1'b1;
      d4    = 4'b0011;
      @(posedge clk); #1;
      saved1 = q1;
      saved4 = q4;
      for (int k = 0; k < 8; k++) begin
         case (k)
            1: clear = 1'b0;
            2: begin d1 = ~d1; d4 = ~d4; end
            4: clear = 1'b1;
            5: begin d1 = ~d1; d4 = 4'b0110; end
            6: d1 = ~d1;
            default: ;
         endcase
         #1;
         chk("glitch_q1", {3'b000, q1}, {3'b000, saved1});
         chk("glitch_q4", q4, saved4);
      end
      final_d1 = d1;
      @(posedge clk); #1;
      chk("glitch_edge_q1", {3'b000, q1}, {3'b000, final_d1});
      chk("glitch_edge_q4", q4, 4'b0110);

      // Randomized traffic, inputs changed on falling edges.
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         clear = ($urandom_range(0, 4) != 0);
         d1    = 1'($urandom);
         d4    = 4'($urandom);
         d4b   = 4'($urandom);
      end

      @(negedge clk);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // Hard stop guard so the run always terminates.
   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time limit, got %0d checks", checks);
      $fatal(1, "timeout");
   end

endmodule : tb_dff_4_sync_clear
`default_nettype wire
